axi_burst_slave_mem: RTL and testbench

AXI_BURST_SLAVE_MEM -- requirements
Module: axi_burst_slave_mem

---
 rtl/axi_burst_slave_mem.sv | 205 ++++++++++++++++++++
 tb/tb_axi_burst_slave_mem.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_slave_mem.sv
// AXI4 INCR full-width burst slave backed by a MEM_DEPTH x DATA_WIDTH byte-writable memory.
// Optional macro AXI_SLV_RANGE_CHECK_EN: out-of-range beats are dropped/zeroed and answered with SLVERR.
module axi_burst_slave_mem #(
    parameter int unsigned            DATA_WIDTH = 256,
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            LEN_WIDTH  = 8,
    parameter int unsigned            MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = ADDR_WIDTH'(32'h4000_0000)
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [LEN_WIDTH-1:0]    S_AXI_AWLEN,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WLAST,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [LEN_WIDTH-1:0]    S_AXI_ARLEN,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RLAST,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned SHIFT  = $clog2(STRB_W);
    // MEM_DEPTH is expected to be a power of two so wrapping is a plain truncation.
    localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);
`ifdef AXI_SLV_RANGE_CHECK_EN
    localparam int unsigned IDX_W  = ADDR_WIDTH;
`else
    localparam int unsigned IDX_W  = MEM_AW;
`endif
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    function automatic logic [IDX_W-1:0] f_word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> SHIFT);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // ---------------- write channel ----------------
    wstate_t               r_wstate, w_wstate_nxt;
    logic [IDX_W-1:0]      r_widx;
    logic [LEN_WIDTH-1:0]  r_wcnt;
    logic                  r_werr;
    logic                  r_awready, r_wready, r_bvalid;
    logic [1:0]            r_bresp;
    logic                  w_aw_hs, w_w_hs, w_b_hs;
    logic                  w_wlast_beat, w_woob, w_beat_err, w_werr_acc, w_mem_we;
    logic [MEM_AW-1:0]     w_waddr;

    assign w_aw_hs      = S_AXI_AWVALID & r_awready;
    assign w_w_hs       = S_AXI_WVALID & r_wready;
    assign w_b_hs       = r_bvalid & S_AXI_BREADY;
    assign w_wlast_beat = (r_wcnt == '0);
`ifdef AXI_SLV_RANGE_CHECK_EN
    assign w_woob       = (r_widx >= IDX_W'(MEM_DEPTH));
`else
    assign w_woob       = 1'b0;
`endif
    // WLAST must coincide exactly with the counted final beat.
    assign w_beat_err   = (S_AXI_WLAST != w_wlast_beat) | w_woob;
    assign w_werr_acc   = r_werr | w_beat_err;
    assign w_mem_we     = w_w_hs & ~w_woob;
    assign w_waddr      = MEM_AW'(r_widx);

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_wlast_beat) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_widx    <= '0;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE);
            r_wready  <= (w_wstate_nxt == W_DATA);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            if (w_aw_hs) begin
                r_widx <= f_word_idx(S_AXI_AWADDR);
                r_wcnt <= S_AXI_AWLEN;
                r_werr <= 1'b0;
            end
            if (w_w_hs) begin
                r_widx <= r_widx + IDX_W'(1);
                r_wcnt <= r_wcnt - LEN_WIDTH'(1);
                r_werr <= w_werr_acc;
                if (w_wlast_beat) r_bresp <= w_werr_acc ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Byte-lane writes; storage is intentionally not reset.
    always_ff @(posedge ACLK) begin
        if (w_mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b]) r_mem[w_waddr][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    rstate_t               r_rstate, w_rstate_nxt;
    logic [IDX_W-1:0]      r_ridx;
    logic [LEN_WIDTH-1:0]  r_rcnt;
    logic                  r_arready, r_rvalid, r_rlast;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_ar_hs, w_r_hs, w_rload, w_roob;
    logic [MEM_AW-1:0]     w_raddr;

    assign w_ar_hs = S_AXI_ARVALID & r_arready;
    assign w_r_hs  = r_rvalid & S_AXI_RREADY;
    assign w_raddr = MEM_AW'(r_ridx);
`ifdef AXI_SLV_RANGE_CHECK_EN
    assign w_roob  = (r_ridx >= IDX_W'(MEM_DEPTH));
`else
    assign w_roob  = 1'b0;
`endif

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rload      = 1'b0;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_ADDR;
            R_ADDR:  w_rstate_nxt = R_DATA;
            R_DATA: begin
                // Load the first beat, or the next one as soon as the current beat is taken.
                w_rload = !r_rvalid || (w_r_hs && !r_rlast);
                if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
            r_ridx    <= '0;
            r_rcnt    <= '0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == R_IDLE);
            if (w_ar_hs) begin
                r_ridx <= f_word_idx(S_AXI_ARADDR);
                r_rcnt <= S_AXI_ARLEN;
            end
            if (w_rload) begin
                r_rdata  <= w_roob ? '0 : r_mem[w_raddr];
                r_rresp  <= w_roob ? RESP_SLVERR : RESP_OKAY;
                r_rlast  <= (r_rcnt == '0);
                r_rvalid <= 1'b1;
                r_ridx   <= r_ridx + IDX_W'(1);
                r_rcnt   <= r_rcnt - LEN_WIDTH'(1);
            end else if (w_r_hs) begin
                r_rvalid <= 1'b0;
                r_rlast  <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RLAST   = r_rlast;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;

endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// Directed bench for axi_burst_slave_mem: bursts, strobes, read stalls, WLAST errors, wrap/range, reset.
module tb_axi_burst_slave_mem;

    localparam int unsigned DW = 256;
    localparam int unsigned AW = 32;
    localparam int unsigned LW = 8;
    localparam int unsigned SW = DW / 8;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [LW-1:0] awlen = '0, arlen = '0;
    logic          awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
    logic [DW-1:0] wdata = '0, rdata;
    logic [SW-1:0] wstrb = '0;
    logic [1:0]    bresp, rresp;
    logic          arvalid = 0, arready, rlast, rvalid, rready = 0;

    always #5 clk = ~clk;

    axi_burst_slave_mem dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] wbuf    [16];
    logic [DW-1:0] rb_data [16];
    logic          rb_last [16];
    logic [1:0]    rb_resp [16];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return {8{32'hA500_0000 | 32'(i)}};
    endfunction

    task automatic ar_hs(input logic [31:0] a, input int len);
        logic hs;
        araddr = a; arlen = LW'(len); arvalid = 1'b1; hs = 1'b0;
        for (int t = 0; t < 50; t++) begin
            hs = arready;
            @(negedge clk);
            if (hs) break;
        end
        arvalid = 1'b0;
        chk("ar_hs", DW'(hs), DW'(1));
    endtask

    // mode 0: RREADY high once data flows; mode 1: RREADY pattern 1,0,0,1,0,0,...
    task automatic axi_read(input logic [31:0] a, input int len, input int mode,
                            output int nb, output int first, output int span);
        logic          stalled, done;
        logic [DW-1:0] held;
        int            last_c;
        ar_hs(a, len);
        nb = 0; first = -1; last_c = -1; stalled = 0; done = 0; held = '0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (rvalid && first < 0) first = c;
            if (stalled) chk("stall_hold", rdata, held);
            rready = (first >= 0) && (mode == 0 || ((c - first) % 3) == 0);
            if (rvalid && rready) begin
                if (nb < 16) begin
                    rb_data[nb] = rdata; rb_last[nb] = rlast; rb_resp[nb] = rresp;
                end
                last_c = c; nb++; done = rlast;
            end
            stalled = rvalid && !rready;
            held = rdata;
            @(negedge clk);
        end
        rready = 1'b0;
        span = last_c - first;
        chk("r_done", DW'(done), DW'(1));
    endtask

    task automatic axi_write(input logic [31:0] a, input int len, input int nbeats, input int wl,
                             input logic [SW-1:0] strb, output int acc, output logic [1:0] resp);
        logic hs;
        awaddr = a; awlen = LW'(len); awvalid = 1'b1; hs = 1'b0;
        for (int t = 0; t < 50; t++) begin
            hs = awready;
            @(negedge clk);
            if (hs) break;
        end
        awvalid = 1'b0;
        chk("aw_hs", DW'(hs), DW'(1));
        acc = 0;
        for (int b = 0; b < nbeats; b++) begin
            wvalid = 1'b1; wdata = wbuf[b]; wstrb = strb; wlast = (b == wl); hs = 1'b0;
            for (int t = 0; t < 5; t++) begin
                hs = wready;
                @(negedge clk);
                if (hs) break;
            end
            if (!hs) break;
            acc++;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1; hs = 1'b0; resp = 2'b11;
        for (int t = 0; t < 50; t++) begin
            hs = bvalid; resp = bresp;
            @(negedge clk);
            if (hs) break;
        end
        bready = 1'b0;
        chk("b_hs", DW'(hs), DW'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            acc, nb, first, span;
        logic [1:0]    resp;
        logic [DW-1:0] exp_w;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_awready", DW'(awready), DW'(0));
        chk("rst_wready",  DW'(wready),  DW'(0));
        chk("rst_bvalid",  DW'(bvalid),  DW'(0));
        chk("rst_arready", DW'(arready), DW'(0));
        chk("rst_rvalid",  DW'(rvalid),  DW'(0));
        chk("rst_rlast",   DW'(rlast),   DW'(0));
        chk("rst_bresp",   DW'(bresp),   DW'(0));
        chk("rst_rresp",   DW'(rresp),   DW'(0));
        chk("rst_rdata",   rdata,        DW'(0));
        rst = 1'b0;
        #1 chk("rel_awready_pre", DW'(awready), DW'(0));
        @(negedge clk);
        chk("rel_awready", DW'(awready), DW'(1));
        chk("rel_arready", DW'(arready), DW'(1));

        // four-beat burst, data 1..4, back-to-back read
        for (int i = 0; i < 4; i++) wbuf[i] = DW'(i + 1);
        axi_write(BASE, 3, 4, 3, '1, acc, resp);
        chk("b4_acc", DW'(acc), DW'(4));
        chk("b4_bresp", DW'(resp), DW'(2'b00));
        axi_read(BASE, 3, 0, nb, first, span);
        chk("b4_nbeats", DW'(nb), DW'(4));
        chk("b4_latency", DW'(first), DW'(2));
        chk("b4_span", DW'(span), DW'(3));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b4_data%0d", i), rb_data[i], DW'(i + 1));
            chk($sformatf("b4_last%0d", i), DW'(rb_last[i]), DW'(i == 3));
            chk($sformatf("b4_rresp%0d", i), DW'(rb_resp[i]), DW'(2'b00));
        end

        // byte-strobe partial write on word 5
        wbuf[0] = '1;
        axi_write(BASE + 32'd160, 0, 1, 0, '1, acc, resp);
        chk("w5_full_bresp", DW'(resp), DW'(2'b00));
        wbuf[0] = '0;
        axi_write(BASE + 32'd160, 0, 1, 0, SW'(1), acc, resp);
        chk("w5_strb_bresp", DW'(resp), DW'(2'b00));
        axi_read(BASE + 32'd160, 0, 0, nb, first, span);
        exp_w = {{(SW-1){8'hFF}}, 8'h00};
        chk("w5_data", rb_data[0], exp_w);
        chk("w5_last", DW'(rb_last[0]), DW'(1));

        // eight-beat read with RREADY stalls
        for (int i = 0; i < 8; i++) wbuf[i] = pat(i);
        axi_write(BASE + 32'd512, 7, 8, 7, '1, acc, resp);
        chk("b8_bresp", DW'(resp), DW'(2'b00));
        axi_read(BASE + 32'd512, 7, 1, nb, first, span);
        chk("b8_nbeats", DW'(nb), DW'(8));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b8_data%0d", i), rb_data[i], pat(i));
            chk($sformatf("b8_last%0d", i), DW'(rb_last[i]), DW'(i == 7));
        end

        // early WLAST: two beats accepted, SLVERR
        for (int i = 0; i < 3; i++) wbuf[i] = pat(100 + i);
        axi_write(BASE + 32'd1280, 1, 3, 0, '1, acc, resp);
        chk("wl_acc", DW'(acc), DW'(2));
        chk("wl_bresp", DW'(resp), DW'(2'b10));
        axi_read(BASE + 32'd1280, 1, 0, nb, first, span);
        chk("wl_nbeats", DW'(nb), DW'(2));
        chk("wl_data0", rb_data[0], pat(100));
        chk("wl_data1", rb_data[1], pat(101));

        // one word past the end: wraps to word 0 or errors under range checking
        axi_read(BASE + 32'd1024 * 32'd32, 0, 0, nb, first, span);
`ifdef AXI_SLV_RANGE_CHECK_EN
        chk("oob_data", rb_data[0], DW'(0));
        chk("oob_rresp", DW'(rb_resp[0]), DW'(2'b10));
`else
        chk("oob_data", rb_data[0], DW'(1));
        chk("oob_rresp", DW'(rb_resp[0]), DW'(2'b00));
`endif

        // reset pulse during beat 2 of an eight-beat read
        ar_hs(BASE + 32'd512, 7);
        rready = 1'b1; nb = 0;
        for (int t = 0; t < 20; t++) begin
            if (rvalid) begin
                if (nb == 1) break;
                nb++;
            end
            @(negedge clk);
        end
        chk("mid_rvalid_pre", DW'(rvalid), DW'(1));
        #2 rst = 1'b1;
        #1 chk("mid_rvalid_async", DW'(rvalid), DW'(0));
        chk("mid_rlast_async", DW'(rlast), DW'(0));
        chk("mid_arready_rst", DW'(arready), DW'(0));
        @(negedge clk);
        rst = 1'b0; rready = 1'b0;
        #1 chk("mid_arready_rel", DW'(arready), DW'(0));
        @(negedge clk);
        chk("mid_arready_1", DW'(arready), DW'(1));
        chk("mid_rvalid_idle", DW'(rvalid), DW'(0));
        axi_read(BASE + 32'd512, 7, 0, nb, first, span);
        chk("post_nbeats", DW'(nb), DW'(8));
        for (int i = 0; i < 8; i++) chk($sformatf("post_data%0d", i), rb_data[i], pat(i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
